// File: rtl/pipe_adder_pkg.sv
// Shared types and default parameters for the pipelined adder.
package pipe_adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } add_op_e;

    localparam int unsigned DEF_WIDTH   = 16;
    localparam int unsigned DEF_STAGE_W = 4;

endpackage

// File: rtl/pipe_add_stage.sv
// One STAGE_W-bit registered slice of the pipelined adder: adds a slice with the
// incoming carry and registers sum, carry-out, carry-into-MSB and valid; holds on i_hold.
module pipe_add_stage #(
    parameter int unsigned STAGE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_hold,
    input  logic               i_valid,
    input  logic [STAGE_W-1:0] i_a,
    input  logic [STAGE_W-1:0] i_b,
    input  logic               i_carry,
    output logic               o_valid,
    output logic [STAGE_W-1:0] o_sum,
    output logic               o_carry,
    output logic               o_carry_msb
);

    logic [STAGE_W:0]   w_full;
    logic               w_cmsb;
    logic               r_valid;
    logic [STAGE_W-1:0] r_sum;
    logic               r_carry;
    logic               r_cmsb;

    always_comb begin
        w_full = {1'b0, i_a} + {1'b0, i_b} + {{STAGE_W{1'b0}}, i_carry};
        // Carry into the slice MSB recovered from the MSB sum bit; valid for STAGE_W = 1.
        w_cmsb = w_full[STAGE_W-1] ^ i_a[STAGE_W-1] ^ i_b[STAGE_W-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cmsb  <= 1'b0;
        end else if (!i_hold) begin
            r_valid <= i_valid;
            r_sum   <= w_full[STAGE_W-1:0];
            r_carry <= w_full[STAGE_W];
            r_cmsb  <= w_cmsb;
        end
    end

    assign o_valid     = r_valid;
    assign o_sum       = r_sum;
    assign o_carry     = r_carry;
    assign o_carry_msb = r_cmsb;

endmodule

// File: rtl/pipe_adder.sv
// Pipelined ADD/SUB, STAGES = WIDTH/STAGE_W slices, global stall, valid/ready handshake.
// Optional saturation of overflowed results under macro PIPE_ADDER_SAT_EN.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned STAGE_W = DEF_STAGE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned STAGES = WIDTH / STAGE_W;

    if (STAGE_W == 0 || WIDTH < 4 || WIDTH > 64 || (WIDTH % STAGE_W) != 0) begin : g_bad_params
        $error("pipe_adder: WIDTH must be 4..64 and an integer multiple of STAGE_W");
    end

    logic               w_stall;
    logic               w_sub;
    logic [WIDTH-1:0]   w_b_eff;
    logic               w_c0;
    logic               w_v   [STAGES];
    logic [STAGE_W-1:0] w_sum [STAGES];
    logic               w_c   [STAGES];
    logic               w_cm  [STAGES];
    logic [WIDTH-1:0]   w_raw;
    logic               w_ovf;

    // Operand and completed-sum bits travelling alongside each stage.
    logic [WIDTH-1:0]   r_a [STAGES];
    logic [WIDTH-1:0]   r_b [STAGES];
    logic [WIDTH-1:0]   r_s [STAGES];

    assign w_stall  = out_valid && !out_ready;
    assign in_ready = !w_stall;
    assign w_sub    = (add_op_e'(op) == OP_SUB);
    assign w_b_eff  = w_sub ? ~b : b;
    assign w_c0     = w_sub ? 1'b1 : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic               w_vin;
        logic               w_cin;
        logic [STAGE_W-1:0] w_a_sl;
        logic [STAGE_W-1:0] w_b_sl;

        if (k == 0) begin : g_first
            assign w_vin  = in_valid;
            assign w_cin  = w_c0;
            assign w_a_sl = a[STAGE_W-1:0];
            assign w_b_sl = w_b_eff[STAGE_W-1:0];
        end else begin : g_next
            assign w_vin  = w_v[k-1];
            assign w_cin  = w_c[k-1];
            assign w_a_sl = r_a[k-1][k*STAGE_W +: STAGE_W];
            assign w_b_sl = r_b[k-1][k*STAGE_W +: STAGE_W];
        end

        pipe_add_stage #(
            .STAGE_W(STAGE_W)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_hold     (w_stall),
            .i_valid    (w_vin),
            .i_a        (w_a_sl),
            .i_b        (w_b_sl),
            .i_carry    (w_cin),
            .o_valid    (w_v[k]),
            .o_sum      (w_sum[k]),
            .o_carry    (w_c[k]),
            .o_carry_msb(w_cm[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
            end
        end else if (!w_stall) begin
            r_a[0] <= a;
            r_b[0] <= w_b_eff;
            for (int unsigned k = 1; k < STAGES; k++) begin
                r_a[k] <= r_a[k-1];
                r_b[k] <= r_b[k-1];
                r_s[k] <= r_s[k-1];
                r_s[k][(k-1)*STAGE_W +: STAGE_W] <= w_sum[k-1];
            end
        end
    end

    always_comb begin
        w_raw = r_s[STAGES-1];
        w_raw[(STAGES-1)*STAGE_W +: STAGE_W] = w_sum[STAGES-1];
    end

    assign w_ovf     = w_c[STAGES-1] ^ w_cm[STAGES-1];
    assign out_valid = w_v[STAGES-1];
    assign cout      = w_c[STAGES-1];
    assign ovf       = w_ovf;

`ifdef PIPE_ADDER_SAT_EN
    always_comb begin
        sum = w_raw;
        if (w_ovf) begin
            sum = r_a[STAGES-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign sum = w_raw;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder (WIDTH=16, STAGE_W=4): behavioural scoreboard
// with per-beat ages plus directed literal vectors, stall and mid-flight reset scenarios.
module tb_pipe_adder;

    localparam int unsigned W  = 16;
    localparam int unsigned SW = 4;
    localparam int          S  = W / SW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          op;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;

    always #5 clk = ~clk;

    pipe_adder #(
        .WIDTH  (W),
        .STAGE_W(SW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .op       (op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        o;
    } res_t;

    typedef struct {
        res_t r;
        int   age;
    } ent_t;

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vc;
        logic        vo;
        logic [15:0] s;
        logic [15:0] s_sat;
        logic        c;
        logic        o;
    } dvec_t;

    dvec_t vecs [6] = '{
        '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 16'h0100, 1'b0, 1'b0},
        '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 16'h7FFF, 1'b0, 1'b1},
        '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0},
        '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 16'h8000, 1'b1, 1'b1},
        '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0},
        '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 16'h0002, 1'b1, 1'b0}
    };

    int   checks  = 0;
    int   errors  = 0;
    int   retired = 0;
    ent_t q[$];
    ent_t m_e;
    logic m_ov;
    logic m_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference from integer arithmetic: unsigned result for sum/carry, signed range for overflow.
    function automatic res_t model(input logic [15:0] va, input logic [15:0] vb,
                                   input logic vc, input logic vo);
        int   ua, ub, sa, sb, u, sg;
        res_t r;
        ua = int'(va);
        ub = int'(vb);
        sa = int'($signed(va));
        sb = int'($signed(vb));
        if (vo) begin
            u   = ua - ub;
            r.c = (ua >= ub);
            sg  = sa - sb;
        end else begin
            u   = ua + ub + int'(vc);
            r.c = (u > 65535);
            sg  = sa + sb + int'(vc);
        end
        r.s = u[15:0];
        r.o = (sg > 32767) || (sg < -32768);
`ifdef PIPE_ADDER_SAT_EN
        if (r.o) r.s = va[15] ? 16'h8000 : 16'h7FFF;
`endif
        return r;
    endfunction

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'h7FFF;
            2:       return 16'h8000;
            3:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Scoreboard: a beat becomes visible after S advancing edges; the pipe advances unless stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_sum", sum, 0);
            chk("rst_cout_ovf", {cout, ovf}, 0);
            q.delete();
        end else begin
            m_ov    = (q.size() > 0) && (q[0].age >= S);
            m_stall = m_ov && !out_ready;
            chk("out_valid", out_valid, m_ov);
            chk("in_ready", in_ready, !m_stall);
            if (m_ov) begin
                chk("sum", sum, q[0].r.s);
                chk("cout", cout, q[0].r.c);
                chk("ovf", ovf, q[0].r.o);
            end
            if (!m_stall) begin
                if (m_ov) begin
                    void'(q.pop_front());
                    retired++;
                end
                foreach (q[i]) q[i].age++;
                if (in_valid) begin
                    m_e.r   = model(a, b, cin, op);
                    m_e.age = 1;
                    q.push_back(m_e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic dir_check(input int idx);
        logic [15:0] es;
        res_t        m;
`ifdef PIPE_ADDER_SAT_EN
        es = vecs[idx].s_sat;
`else
        es = vecs[idx].s;
`endif
        m = model(vecs[idx].va, vecs[idx].vb, vecs[idx].vc, vecs[idx].vo);
        chk("model_sum", m.s, es);
        chk("model_cout", m.c, vecs[idx].c);
        chk("model_ovf", m.o, vecs[idx].o);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a   = vecs[idx].va;
        b   = vecs[idx].vb;
        cin = vecs[idx].vc;
        op  = vecs[idx].vo;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("lat_early", out_valid, 0);
        step();
        chk("dir_valid", out_valid, 1);
        chk("dir_sum", sum, es);
        chk("dir_cout", cout, vecs[idx].c);
        chk("dir_ovf", ovf, vecs[idx].o);
        step();
    endtask

    initial begin
        int sent;
        int r0;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        op        = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("por_out_valid", out_valid, 0);
        chk("por_sum", sum, 0);
        chk("por_in_ready", in_ready, 1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("post_rst_in_ready", in_ready, 1);
        step();

        for (int i = 0; i < 6; i++) dir_check(i);

        // 8 beats, out_ready low on cycles 5..7
        sent = 0;
        r0   = retired;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            in_valid  = (sent < 8);
            a         = 16'($urandom);
            b         = 16'($urandom);
            cin       = 1'($urandom);
            op        = 1'($urandom);
            out_ready = !(cyc >= 5 && cyc <= 7);
            #1;
            chk("stall_in_ready", in_ready, (cyc >= 5 && cyc <= 7) ? 0 : 1);
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) step();
        chk("stall_sent", sent, 8);
        chk("stall_retired", retired - r0, 8);

        // Reset with one result at the output and three beats behind it
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            a        = pick();
            b        = pick();
            cin      = 1'($urandom);
            op       = 1'($urandom);
            step();
        end
        in_valid = 1'b0;
        chk("pre_rst_out_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_sum", sum, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rel_in_ready", in_ready, 1);
        repeat (6) step();
        dir_check(1);

        // Randomized traffic with random backpressure
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = pick();
            b         = pick();
            cin       = 1'($urandom);
            op        = 1'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (S + 4) step();
        chk("drain_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
